// File: rtl/pos_sync_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pos_sync_pkg
//  Description : Shared constants for the mouse position synchroniser path.
//                Covers channel layout and default filter depths.
//  Revision    : 1.0 - initial release
// ============================================================================
package pos_sync_pkg;

  // Position bus layout used by the mouse decoder and the game/draw logic
  localparam int POS_WIDTH    = 12;
  localparam int POS_CHANNELS = 2;
  localparam int POS_CH_X     = 0;
  localparam int POS_CH_Y     = 1;

  // Default synchroniser depth and stability window for the mouse path
  localparam int POS_STAGES        = 2;
  localparam int POS_STABLE_CYCLES = 4;

  // Width of a counter that must hold the values 0..max_count inclusive
  function automatic int cnt_width(input int max_count);
    return (max_count < 1) ? 1 : $clog2(max_count + 1);
  endfunction

endpackage : pos_sync_pkg
`default_nettype wire

// File: rtl/sync_chain.sv
`default_nettype none
// ============================================================================
//  Module      : sync_chain
//  Description : Plain multi-flop synchroniser over a WIDTH-bit bus. Every
//                stage resets asynchronously to zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_chain #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_stage [STAGES];

  // Shift the asynchronous input one stage further down the chain each edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        r_stage[i] <= '0;
      end
    end else begin
      r_stage[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign q = r_stage[STAGES-1];

endmodule : sync_chain
`default_nettype wire

// File: rtl/pos_sync_filter.sv
`default_nettype none
// ============================================================================
//  Module      : pos_sync_filter
//  Description : Multi-channel input synchroniser with a stability filter.
//                The synchronised word is committed to data_out only after
//                holding unchanged for STABLE_CYCLES cycles; each commit
//                raises a one-cycle upd_valid and a per-channel change mask.
//  Revision    : 1.0 - initial release
// ============================================================================
module pos_sync_filter
  import pos_sync_pkg::*;
#(
  parameter int WIDTH         = POS_WIDTH,
  parameter int CHANNELS      = POS_CHANNELS,
  parameter int STAGES        = POS_STAGES,
  parameter int STABLE_CYCLES = POS_STABLE_CYCLES
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] data_in,
  input  logic                      hold,
  output logic [CHANNELS*WIDTH-1:0] data_out,
  output logic                      upd_valid,
  output logic [CHANNELS-1:0]       chg_mask
);

  localparam int BUS_W = CHANNELS * WIDTH;
  localparam int CNT_W = cnt_width(STABLE_CYCLES);

  localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

  logic [BUS_W-1:0]    w_sync_word;
  logic [BUS_W-1:0]    r_cand;
  logic [BUS_W-1:0]    w_cand_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic                w_commit;
  logic [CHANNELS-1:0] w_chg;
  logic [BUS_W-1:0]    r_data_out;
  logic                r_upd_valid;
  logic [CHANNELS-1:0] r_chg_mask;

  // One synchroniser over the whole bus so all channels share identical latency
  sync_chain #(
    .WIDTH  (BUS_W),
    .STAGES (STAGES)
  ) u_sync_chain (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (data_in),
    .q     (w_sync_word)
  );

  // Track the current candidate word and how long it has been stable
  always_comb begin
    w_cand_nxt = r_cand;
    w_cnt_nxt  = r_cnt;
    if (w_sync_word != r_cand) begin
      w_cand_nxt = w_sync_word;
      w_cnt_nxt  = c_cnt_one;
    end else if (r_cnt < c_cnt_max) begin
      w_cnt_nxt  = r_cnt + c_cnt_one;
    end
  end

  // Per-channel difference between the incoming candidate and the committed word
  for (genvar gc = 0; gc < CHANNELS; gc++) begin : g_chg
    assign w_chg[gc] = (w_cand_nxt[gc*WIDTH +: WIDTH] != r_data_out[gc*WIDTH +: WIDTH]);
  end

  // Evaluated every cycle, so a word that settled during hold commits once hold drops
  assign w_commit = !hold && (w_cnt_nxt == c_cnt_max) && (w_cand_nxt != r_data_out);

  // Candidate and stability counter keep running regardless of hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cand <= '0;
      r_cnt  <= '0;
    end else begin
      r_cand <= w_cand_nxt;
      r_cnt  <= w_cnt_nxt;
    end
  end

  // Commit the candidate to the outputs and pulse the update strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data_out  <= '0;
      r_upd_valid <= 1'b0;
      r_chg_mask  <= '0;
    end else if (w_commit) begin
      r_data_out  <= w_cand_nxt;
      r_upd_valid <= 1'b1;
      r_chg_mask  <= w_chg;
    end else begin
      r_upd_valid <= 1'b0;
      r_chg_mask  <= '0;
    end
  end

  assign data_out  = r_data_out;
  assign upd_valid = r_upd_valid;
  assign chg_mask  = r_chg_mask;

endmodule : pos_sync_filter
`default_nettype wire

// File: tb/tb_pos_sync_filter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pos_sync_filter
//  Description : Scoreboard bench for pos_sync_filter. The reference model
//                keeps the history of sampled inputs and decides a commit by
//                checking that the last STABLE_CYCLES synchronised words are
//                identical and differ from the committed word.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pos_sync_filter;
  import pos_sync_pkg::*;

  localparam int W   = POS_WIDTH;
  localparam int CH  = POS_CHANNELS;
  localparam int STG = POS_STAGES;
  localparam int STB = POS_STABLE_CYCLES;
  localparam int BW  = W * CH;

  typedef struct {
    logic          upd;
    logic [BW-1:0] data;
    logic [CH-1:0] chg;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [BW-1:0] data_in = '0;
  logic          hold = 1'b0;
  logic [BW-1:0] data_out;
  logic          upd_valid;
  logic [CH-1:0] chg_mask;

  int n_cmp = 0;
  int n_bad = 0;
  int n_exp_pulses = 0;
  int n_dut_pulses = 0;

  exp_t          sb[$];
  logic [BW-1:0] sampled[$];
  logic [BW-1:0] pre_sync[$];
  int            edge_k = 0;
  logic [BW-1:0] m_out = '0;

  pos_sync_filter #(
    .WIDTH         (W),
    .CHANNELS      (CH),
    .STAGES        (STG),
    .STABLE_CYCLES (STB)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .data_in   (data_in),
    .hold      (hold),
    .data_out  (data_out),
    .upd_valid (upd_valid),
    .chg_mask  (chg_mask)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [BW-1:0] mk(input logic [W-1:0] y, input logic [W-1:0] x);
    return {y, x};
  endfunction

  // Reference model: evaluate one rising edge from the sampled input history
  task automatic model_edge(input logic [BW-1:0] d, input logic h);
    logic [BW-1:0] pre;
    bit            stable;
    exp_t          e;
    edge_k++;
    pre = (edge_k <= STG) ? '0 : sampled[edge_k-STG-1];
    sampled.push_back(d);
    pre_sync.push_back(pre);
    stable = (edge_k >= STB);
    for (int i = 1; i < STB; i++) begin
      if (stable && pre_sync[edge_k-1-i] != pre) stable = 0;
    end
    e.upd = 1'b0;
    e.chg = '0;
    if (!h && stable && pre != m_out) begin
      e.upd = 1'b1;
      for (int c = 0; c < CH; c++) e.chg[c] = (pre[c*W +: W] != m_out[c*W +: W]);
      m_out = pre;
      n_exp_pulses++;
    end
    e.data = m_out;
    sb.push_back(e);
  endtask

  task automatic model_reset();
    sampled.delete();
    pre_sync.delete();
    edge_k = 0;
    m_out  = '0;
  endtask

  // Drive one cycle of stimulus; returns at the following falling edge
  task automatic step(input logic [BW-1:0] d, input logic h, input int n);
    for (int i = 0; i < n; i++) begin
      data_in = d;
      hold    = h;
      @(posedge clk);
      model_edge(d, h);
      @(negedge clk);
    end
  endtask

  // Asynchronous reset pulse placed entirely between two rising edges
  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    #1;
    check("rst_data_out",  64'(data_out),  64'd0);
    check("rst_upd_valid", 64'(upd_valid), 64'd0);
    check("rst_chg_mask",  64'(chg_mask),  64'd0);
    #1 rst_n = 1'b1;
    model_reset();
  endtask

  // Monitor: pop one expectation per evaluated edge and compare
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && upd_valid) n_dut_pulses++;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("upd_valid", 64'(upd_valid), 64'(e.upd));
      check("data_out",  64'(data_out),  64'(e.data));
      check("chg_mask",  64'(chg_mask),  64'(e.chg));
    end
  end

  initial begin
    logic [BW-1:0] cur;
    logic [W-1:0]  x, y;
    logic          h;
    int            sel;

    // Reset state before any edge is evaluated
    #3;
    check("por_data_out",  64'(data_out),  64'd0);
    check("por_upd_valid", 64'(upd_valid), 64'd0);
    check("por_chg_mask",  64'(chg_mask),  64'd0);
    #3 rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    model_reset();

    // All-zero input: counter saturates with no pulse
    step(mk(12'h000, 12'h000), 1'b0, 20);
    // Both channels step
    step(mk(12'h0F0, 12'h140), 1'b0, 12);
    // Only x changes
    step(mk(12'h0F0, 12'h141), 1'b0, 12);
    // Short glitch on x is rejected
    step(mk(12'h0F0, 12'h3FF), 1'b0, 3);
    step(mk(12'h0F0, 12'h141), 1'b0, 10);
    // Change under hold, commit when released
    step(mk(12'h0F0, 12'h200), 1'b1, 10);
    step(mk(12'h0F0, 12'h200), 1'b0, 5);
    // Reset mid-count, then restart from the same input
    step(mk(12'h0AA, 12'h055), 1'b0, 3);
    pulse_reset();
    step(mk(12'h0AA, 12'h055), 1'b0, 12);

    // Randomized segments
    cur = mk(12'h0AA, 12'h055);
    h   = 1'b0;
    for (int seg = 0; seg < 300; seg++) begin
      x   = cur[W-1:0];
      y   = cur[2*W-1:W];
      sel = $urandom_range(0, 5);
      case (sel)
        0: x = W'($urandom_range(0, 7));
        1: y = W'($urandom_range(0, 7));
        2: begin x = W'($urandom); y = W'($urandom); end
        3: begin x = W'($urandom_range(0, 3)); y = W'($urandom_range(0, 3)); end
        default: ;
      endcase
      cur = mk(y, x);
      if ($urandom_range(0, 7) == 0) h = ~h;
      step(cur, h, $urandom_range(1, 8));
      if ($urandom_range(0, 39) == 0) pulse_reset();
    end
    step(cur, 1'b0, STG + STB + 2);

    @(negedge clk);
    check("pulse_count", 64'(n_dut_pulses), 64'(n_exp_pulses));
    check("sb_drained",  64'(sb.size()),    64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Absolute time limit so the run always ends
  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_pos_sync_filter
`default_nettype wire

// File: doc/pos_sync_filter.md
# pos_sync_filter

Parametrised multi-channel input synchroniser with a stability filter. It replaces the fixed 12-bit, two-channel, two-stage position buffer between the mouse decoder and the game/draw logic. Each bit passes through a configurable-depth flop chain. The synchronised word, all channels together, is committed to the outputs only after it has held unchanged for a programmable number of cycles, which rejects torn multi-bit samples and short glitches. Each commit raises a one-cycle update strobe and a per-channel changed mask.

## Interface
- WIDTH, 12, bits per channel (≥1)
- CHANNELS, 2, number of channels; channel 0 = x, channel 1 = y in the mouse path (≥1)
- STAGES, 2, synchroniser flops per bit (≥2)
- STABLE_CYCLES, 4, consecutive equal synchronised samples required before commit (≥1)

- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- data_in  in  CHANNELS*WIDTH  asynchronous input; channel c at bits [c*WIDTH +: WIDTH]
- hold  in  1  synchronous; while 1, no commit occurs
- data_out  out  CHANNELS*WIDTH  last committed word; reset 0
- upd_valid  out  1  one-cycle pulse on the cycle data_out takes a new value; reset 0
- chg_mask  out  CHANNELS  bit c = channel c differs from previous data_out; valid with upd_valid, otherwise 0; reset 0

## Operation
- Sync chain: data_in → s[0] → … → s[STAGES-1] on every clk edge. sync_word = s[STAGES-1].
- Candidate register cand (CHANNELS*WIDTH) and counter cnt (width $clog2(STABLE_CYCLES+1)).
  - If sync_word != cand, then cand_nxt = sync_word and cnt_nxt = 1.
  - Otherwise cand_nxt = cand and cnt_nxt = min(cnt+1, STABLE_CYCLES). cnt saturates and never wraps.
- Commit when !hold && cnt_nxt == STABLE_CYCLES && cand_nxt != data_out:
  - data_out ← cand_nxt
  - upd_valid ← 1
  - chg_mask[c] ← (channel c of cand_nxt != channel c of data_out)
- Otherwise upd_valid ← 0, chg_mask ← 0, data_out holds.
- Commit is level-evaluated:
  - After a commit, cand == data_out, so there is no repeat pulse.
  - A value that becomes stable while hold=1 commits on the first edge with hold=0.
- hold does not stall the sync chain or cnt.
- Glitch handling: any word held for fewer than STABLE_CYCLES synchronised cycles never reaches data_out. A change in any channel restarts stability for the whole bus, so channels always commit coherently.
- All registers, including s[*], reset asynchronously to 0. After reset cand = 0 and cnt = 0. With data_in = 0, cnt climbs to STABLE_CYCLES with no pulse.

## Timing
- Edge counting: edge 1 is the first rising edge at which a new data_in is sampled, and data_in stays stable afterwards.
  - sync_word shows the new value after edge STAGES.
  - cand loads it at edge STAGES+1 with cnt = 1.
  - data_out and upd_valid update at edge STAGES+STABLE_CYCLES. Defaults: edge 6.
- upd_valid is high for exactly one cycle per commit. Back-to-back commits are at least STABLE_CYCLES cycles apart.
- When STABLE_CYCLES = 1, commit happens at the same edge cand loads (edge STAGES+1).
- Reset asserted mid-operation clears all outputs immediately (asynchronously). The first possible commit after release requires a nonzero input that has been stable for STAGES+STABLE_CYCLES edges.
- No combinational path from any input to any output.

## Structure
- Package pos_sync_pkg holds:
  - POS_WIDTH = 12, POS_CHANNELS = 2, POS_CH_X = 0, POS_CH_Y = 1
  - the default STAGES and STABLE_CYCLES constants used by the mouse path
- Sub-module sync_chain (parameters WIDTH, STAGES; ports clk, rst_n, d, q): a pure flop chain, instantiated once over the full bus.
- The filter/commit logic lives in pos_sync_filter.

## Test plan
- Reset, then data_in = {y=0x000, x=0x000} for 20 cycles -> upd_valid never asserted, data_out = 0.
- Step to {y=0x0F0, x=0x140}, stable (defaults) -> data_out = 0x0F0_140 and upd_valid = 1 at edge 6 only, chg_mask = 2'b11, no further pulses.
- Change only x to 0x141 -> one pulse, chg_mask = 2'b01, y unchanged.
- x glitch to 0x3FF for 3 cycles, then back to 0x141 -> no upd_valid, data_out stays 0x0F0_141.
- hold=1, step x to 0x200 and keep hold for 10 cycles -> no pulse. Drop hold -> commit on the next edge, chg_mask = 2'b01.
- rst_n pulsed low mid-count after a step -> data_out, upd_valid and chg_mask read 0 before the next clk edge. After release, commit occurs STAGES+STABLE_CYCLES edges after sampling resumes.
